// File: rtl/multiword_adder_seq_pkg.sv
// Purpose:      shared types and default sizes for the multi-word sequential adder.
// Latency:      n/a (types and constants only).
// Backpressure: n/a.
package multiword_adder_seq_pkg;

  localparam int DEF_N         = 8;
  localparam int DEF_MAX_WORDS = 8;
  localparam int DEF_IDX_W     = $clog2(DEF_MAX_WORDS);

  // IDLE: the next word begins a new operation. MID: a carry chain is in flight.
  typedef enum logic {
    IDLE = 1'b0,
    MID  = 1'b1
  } state_t;

  // One registered result word, as presented on the output port.
  typedef struct packed {
    logic [DEF_N-1:0]      sum;
    logic                  carry;
    logic                  ovf;
    logic                  last;
    logic [DEF_IDX_W-1:0]  idx;
    logic                  err;
  } out_word_t;

endpackage

// File: rtl/word_adder.sv
// Purpose:      N-bit ripple-carry adder, {cout,sum} = a + b + cin.
// Latency:      combinational.
// Backpressure: none.
// Ports: a, b (N-bit operands), cin (carry in), sum (N-bit result), cout (carry out).
module word_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[N];

endmodule

// File: rtl/multiword_adder_seq.sv
// Purpose:      adds/subtracts wide operands streamed LS word first, carry registered between words.
// Latency:      one cycle, one word per cycle at full rate.
// Backpressure: single output register; in_ready = !out_valid | out_ready, holds all state while stalled.
// Ports: clk/rst; in_valid/in_ready with in_a, in_b, in_first, in_last, in_sub;
//        out_valid/out_ready with out_sum, out_carry, out_ovf, out_last, out_idx, out_err.
module multiword_adder_seq
  import multiword_adder_seq_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_err
);

  state_t           state, state_nxt;
  logic             carry_reg, carry_nxt;
  logic             mode_reg, mode_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;

  out_word_t        out_q;
  logic             out_vld_q;

  logic             accept;
  logic             start;
  logic             mode;
  logic             cin;
  logic [N-1:0]     b_eff;
  logic [N-1:0]     sum;
  logic             cout;
  logic [IDX_W-1:0] cur_idx;
  logic             force_last;
  logic             is_last;
  logic             err;
  logic             ovf;

  assign in_ready = !out_vld_q | out_ready;
  assign accept   = in_valid & in_ready;

  // A word starts a new operation when flagged first or when nothing is in flight;
  // a first flag mid-operation abandons the old chain.
  assign start   = in_first | (state == IDLE);
  assign mode    = start ? in_sub : mode_reg;
  assign b_eff   = mode ? ~in_b : in_b;
  // Subtract is A + ~B + 1, so the first word's carry-in equals the mode bit.
  assign cin     = start ? mode : carry_reg;
  assign cur_idx = start ? '0 : idx;

  word_adder #(.N(N)) u_word_adder (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // An operation that reaches the word limit without a last flag is truncated there.
  assign force_last = (cur_idx == IDX_W'(MAX_WORDS - 1)) & !in_last;
  assign is_last    = in_last | force_last;

  assign err = ((state == IDLE) & !in_first)
             | ((state == MID)  &  in_first)
             | force_last;

  assign ovf = is_last
             & (in_a[N-1] == b_eff[N-1])
             & (sum[N-1]  != in_a[N-1]);

  always_comb begin
    state_nxt = state;
    carry_nxt = carry_reg;
    mode_nxt  = mode_reg;
    idx_nxt   = idx;
    if (accept) begin
      if (is_last) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end else begin
        state_nxt = MID;
        carry_nxt = cout;
        mode_nxt  = mode;
        idx_nxt   = cur_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      carry_reg <= 1'b0;
      mode_reg  <= 1'b0;
      idx       <= '0;
    end else begin
      state     <= state_nxt;
      carry_reg <= carry_nxt;
      mode_reg  <= mode_nxt;
      idx       <= idx_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (accept) begin
      out_vld_q <= 1'b1;
      out_q     <= '{sum: sum, carry: cout, ovf: ovf, last: is_last, idx: cur_idx, err: err};
    end else if (out_ready) begin
      out_vld_q <= 1'b0;
    end
  end

  assign out_valid = out_vld_q;
  assign out_sum   = out_q.sum;
  assign out_carry = out_q.carry;
  assign out_ovf   = out_q.ovf;
  assign out_last  = out_q.last;
  assign out_idx   = out_q.idx;
  assign out_err   = out_q.err;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Purpose:      directed bench for multiword_adder_seq with an expected-word queue.
// Latency:      expects each accepted word on the outputs one cycle later.
// Backpressure: exercises out_ready stalls, full-rate streaming and reset mid-operation.
module tb_multiword_adder_seq;
  import multiword_adder_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_first;
  logic       in_last;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_carry;
  logic       out_ovf;
  logic       out_last;
  logic [2:0] out_idx;
  logic       out_err;

  int n_vec = 0;
  int n_err = 0;
  out_word_t exp_q[$];

  multiword_adder_seq #(.N(8), .MAX_WORDS(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic out_word_t obs_word();
    out_word_t o;
    o = '{sum: out_sum, carry: out_carry, ovf: out_ovf, last: out_last, idx: out_idx, err: out_err};
    return o;
  endfunction

  function automatic out_word_t mk(input logic [7:0] s, input logic c, input logic v,
                                   input logic l, input int i, input logic e);
    out_word_t r;
    r = '{sum: s, carry: c, ovf: v, last: l, idx: 3'(i), err: e};
    return r;
  endfunction

  // Reference for word i of an nw-word operation, taken from full-width arithmetic.
  function automatic out_word_t model(input logic [63:0] a, input logic [63:0] b,
                                      input logic sub, input int nw, input int i);
    logic [71:0] aa, bb, m, low;
    int w;
    out_word_t r;
    w   = 8 * (i + 1);
    aa  = {8'h00, a};
    bb  = {8'h00, (sub ? ~b : b)};
    m   = (72'd1 << w) - 72'd1;
    low = (aa & m) + (bb & m) + {71'd0, sub};
    r.sum   = low[8*i +: 8];
    r.carry = low[w];
    r.last  = (i == nw - 1);
    r.idx   = 3'(i);
    r.err   = 1'b0;
    r.ovf   = r.last && (aa[w-1] == bb[w-1]) && (low[w-1] != aa[w-1]);
    return r;
  endfunction

  // Checks every output transfer against the head of the expected queue.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
      else                   chk("out_word", 64'(obs_word()), 64'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic first,
                      input logic last, input logic sub, input out_word_t e, input logic push);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_first = first; in_last = last; in_sub = sub;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [63:0] a, input logic [63:0] b, input logic sub, input int nw);
    for (int i = 0; i < nw; i++)
      send(a[8*i +: 8], b[8*i +: 8], i == 0, i == nw - 1, sub, model(a, b, sub, nw, i), 1'b1);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    @(negedge clk);
    #3;
    while ((exp_q.size() != 0 || out_valid) && waited < 50) begin
      @(negedge clk);
      #3;
      waited++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fields", 64'(obs_word()), 64'd0);
    rst = 1'b0;

    // 0x12FF + 0x0001
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0), 1'b1);
    send(8'h12, 8'h00, 1'b0, 1'b1, 1'b0, mk(8'h13, 1'b0, 1'b0, 1'b1, 1, 1'b0), 1'b1);
    // 0x0100 - 0x0001
    send(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0, 0, 1'b0), 1'b1);
    send(8'h01, 8'h00, 1'b0, 1'b1, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b1, 1, 1'b0), 1'b1);
    // single-word operations
    send(8'h7F, 8'h01, 1'b1, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b1, 0, 1'b0), 1'b1);
    send(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0), 1'b1);

    // 4-word add with a 3-cycle stall after the first word
    send(8'hEF, 8'h78, 1'b1, 1'b0, 1'b0, model(64'h89ABCDEF, 64'h12345678, 1'b0, 4, 0), 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hCD; in_b = 8'h56; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_word", 64'(obs_word()), 64'(exp_q[0]));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 1; i < 4; i++)
      send(8'(64'h89ABCDEF >> (8*i)), 8'(64'h12345678 >> (8*i)), 1'b0, i == 3, 1'b0,
           model(64'h89ABCDEF, 64'h12345678, 1'b0, 4, i), 1'b1);

    // back-to-back subtracts, including signed overflow on the top word
    send_op(64'h00001234, 64'h00005678, 1'b1, 4);
    send_op(64'h00800000, 64'h00000001, 1'b1, 3);
    send_op(64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 1'b0, 8);

    // first flag on the second word restarts as a subtract with cin = 1
    send(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, mk(8'h30, 1'b0, 1'b0, 1'b0, 0, 1'b0), 1'b1);
    send(8'h05, 8'h03, 1'b1, 1'b1, 1'b1, mk(8'h02, 1'b1, 1'b0, 1'b1, 0, 1'b1), 1'b1);

    // eight words with no last flag: the eighth is forced last
    for (int i = 0; i < 8; i++)
      send(8'hFF, 8'h01, i == 0, 1'b0, 1'b0,
           mk((i == 0) ? 8'h00 : 8'h01, 1'b1, 1'b0, i == 7, i, i == 7), 1'b1);
    // back in IDLE: a clean word after the truncated operation
    send(8'h21, 8'h12, 1'b1, 1'b1, 1'b0, mk(8'h33, 1'b0, 1'b0, 1'b1, 0, 1'b0), 1'b1);
    drain();

    // reset while a word is held in the output register mid-operation
    @(negedge clk);
    out_ready = 1'b0;
    send(8'h33, 8'h44, 1'b1, 1'b0, 1'b0, mk(8'h77, 1'b0, 1'b0, 1'b0, 0, 1'b0), 1'b0);
    @(negedge clk);
    #1;
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(8'h0A, 8'h05, 1'b0, 1'b1, 1'b0, mk(8'h0F, 1'b0, 1'b0, 1'b1, 0, 1'b1), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
